// File: rtl/borrow_lookahead_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, each trial
// subtraction done by a flattened borrow-lookahead subtractor.
module borrow_lookahead_divider #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial, subtrahend, gen, prop;
  logic [WIDTH+1:0] borrow;
  logic [WIDTH-1:0] diff;
  logic             chain_prop;
  logic             bout;

  assign trial      = {rem_q, quo_q[WIDTH-1]};
  assign subtrahend = {1'b0, dvsr_q};

  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_gp
    assign gen[gi]  = ~trial[gi] & subtrahend[gi];
    assign prop[gi] = ~(trial[gi] ^ subtrahend[gi]);
  end

  // b[i+1] = G_i | P_i G_{i-1} | P_i P_{i-1} G_{i-2} | ... ; b_0 = 0
  always_comb begin
    borrow     = '0;
    chain_prop = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      chain_prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        borrow[i+1] = borrow[i+1] | (gen[j] & chain_prop);
        chain_prop  = chain_prop & prop[j];
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
    assign diff[gi] = trial[gi] ^ subtrahend[gi] ^ borrow[gi];
  end

  assign bout = borrow[WIDTH+1];

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_divisor != '0) begin
            dvsr_d  = i_divisor;
            rem_d   = '0;
            quo_d   = i_dividend;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = S_CALC;
          end else begin
            res_quo_d = '1;
            res_rem_d = i_dividend;
            dz_d      = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_CALC: begin
        // Restoring step: keep the shifted partial remainder when the trial borrows.
        rem_d = bout ? trial[WIDTH-1:0] : diff;
        quo_d = {quo_q[WIDTH-2:0], ~bout};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_quo_d = quo_d;
          res_rem_d = rem_d;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign o_busy        = (state_q == S_CALC);
  assign o_done        = (state_q == S_DONE);
  assign o_quotient    = res_quo_q;
  assign o_remainder   = res_rem_q;
  assign o_div_by_zero = dz_q;

endmodule

// File: tb/tb_borrow_lookahead_divider.sv
// Randomized and directed checks of borrow_lookahead_divider against plain
// integer division, including latency, pulse width, reset abort and throughput.
module tb_borrow_lookahead_divider;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int tests_run;
  int tests_failed;

  borrow_lookahead_divider #(.WIDTH(WIDTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_busy       (busy),
    .o_done       (done),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero returns all ones / dividend.
  task automatic model(input int a, input int b, output int q, output int r, output int dz,
                       output int lat, output int nbusy);
    if (b == 0) begin
      q = MAXV; r = a; dz = 1; lat = 0; nbusy = 0;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = WIDTH; nbusy = WIDTH;
    end
  endtask

  task automatic run_div(input int a, input int b, input bit interfere);
    int q, r, dz, lat, nbusy;
    int seen_lat, busy_cnt;
    model(a, b, q, r, dz, lat, nbusy);
    @(negedge clk);
    start    = 1'b1;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
    seen_lat = -1;
    busy_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen_lat = n;
        break;
      end
      if (interfere && n == 1) begin
        start    = 1'b1;
        dividend = 4'd5;
        divisor  = 4'd5;
      end else if (interfere && n == 2) begin
        start = 1'b0;
      end
    end
    check_eq("latency", seen_lat, lat);
    check_eq("busy_cycles", busy_cnt, nbusy);
    check_eq("quotient", quotient, q);
    check_eq("remainder", remainder, r);
    check_eq("div_by_zero", div_by_zero, dz);
    $display("[TB] %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, quotient, remainder,
             div_by_zero, seen_lat);
    @(negedge clk);
    check_eq("done_pulse_width", done, 0);
  endtask

  initial begin
    int done_idx[$];
    int dones;
    int hold_q, hold_r;
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    #3;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_quotient", quotient, 0);
    check_eq("reset_remainder", remainder, 0);
    check_eq("reset_dz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div(13, 4, 1'b0);
    run_div(15, 1, 1'b0);
    run_div(3, 7, 1'b0);
    run_div(15, 15, 1'b0);
    run_div(9, 0, 1'b0);
    run_div(14, 3, 1'b1);

    // Results persist through IDLE.
    hold_q = int'(quotient);
    hold_r = int'(remainder);
    repeat (3) @(negedge clk);
    check_eq("hold_quotient", quotient, 4);
    check_eq("hold_remainder", remainder, 2);
    $display("[TB] hold q=%0d r=%0d", hold_q, hold_r);

    // Asynchronous reset in the middle of a division.
    run_div(13, 4, 1'b0);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd11;
    divisor  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_quotient", quotient, 0);
    check_eq("abort_remainder", remainder, 0);
    check_eq("abort_dz", div_by_zero, 0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("abort_no_done", dones, 0);
    $display("[TB] reset mid-calc: q=%0d r=%0d dones=%0d", quotient, remainder, dones);
    run_div(11, 2, 1'b0);

    // Start held high: back-to-back divisions.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    for (int n = 0; n < 40 && done_idx.size() < 3; n++) begin
      @(negedge clk);
      if (done) begin
        done_idx.push_back(n);
        check_eq("held_quotient", quotient, 2);
        check_eq("held_remainder", remainder, 2);
        $display("[TB] held 12/5 -> q=%0d r=%0d at cycle %0d", quotient, remainder, n);
      end
    end
    start = 1'b0;
    check_eq("held_done_count", done_idx.size(), 3);
    if (done_idx.size() == 3) begin
      check_eq("held_interval_1", done_idx[1] - done_idx[0], WIDTH + 2);
      check_eq("held_interval_2", done_idx[2] - done_idx[1], WIDTH + 2);
    end
    repeat (3) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      run_div(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
